dec_symbol_search: RTL
======================

# dec_symbol_search

Multi-cycle symbol search for the AV1 arithmetic decoder, the decode-side counterpart of the encoder's first stage. Given the current range RNG, the top 16 bits of the decoder window DIF and the symbol count, it walks the inverse-CDF table one entry per cycle from an external synchronous memory. It stops at the first symbol whose scaled bound v is ≤ DIF, then emits the decoded symbol, the un-normalized new range and the updated window top. Renormalization and bit refill are handled downstream.

## Interface
- RANGE_WIDTH, 16, width of RNG/DIF/cdf_data and results
- SYMBOL_WIDTH, 4, symbol index width; NSYMS is SYMBOL_WIDTH+1 bits
- clk_dec_search  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  high only in IDLE and not in reset
- RNG  in  16  current range (normalized, 32768..65535)
- DIF  in  16  window top c
- NSYMS  in  5  number of symbols, legal 2..16
- cdf_rd_en  out  1  memory read strobe
- cdf_addr  out  4  inverse-CDF index k
- cdf_data  in  16  icdf[k], valid exactly one cycle after the cdf_rd_en/cdf_addr cycle
- out_valid  out  1  result valid
- out_ready  in  1  result accepted
- out_symbol  out  4  decoded symbol
- RNG_NEW  out  16  u − v (before renormalization)
- DIF_NEW  out  16  DIF − v
- err_nsyms  out  1  request had illegal NSYMS

## Operation
- N = NSYMS − 1. Latch RNG, DIF and N at accept (in_valid & in_ready).
- v_k = (((RNG>>8) × (icdf[k]>>6)) >> 1) + 4×(N−k).
- Widths: 8b × 10b gives an 18-bit product; after >>1, v_k is kept in 17 bits and is guaranteed < 65536. Compute 4×(N−k) in 6 bits.
- u starts at RNG.
- States:
  - IDLE: in_ready=1; cdf_addr=0; cdf_rd_en=in_valid & legal NSYMS. Legal accept → SEARCH with k=0. Illegal accept (NSYMS<2 or >16) → DONE with err_nsyms=1, out_symbol=0, RNG_NEW=RNG, DIF_NEW=DIF, and no memory read.
  - SEARCH (k): evaluate v_k from cdf_data.
    - If DIF < v_k and k<N: u←v_k, k←k+1; drive cdf_addr=k+1 and cdf_rd_en=1 this cycle.
    - Otherwise (DIF ≥ v_k, or k==N, forced): register out_symbol=k, RNG_NEW=u−v_k, DIF_NEW=DIF−v_k, → DONE; cdf_rd_en=0.
  - DONE: out_valid=1; outputs held stable. When out_ready=1 → IDLE.
- k==N forces termination even if icdf[N]≠0. With well-formed tables, v_N=0.
- Reset in any state: → IDLE at the next edge. Search state is discarded and no result is emitted for the aborted request.

## Timing
- Reset values: out_valid=0, err_nsyms=0, out_symbol=0, RNG_NEW=0, DIF_NEW=0, cdf_rd_en=0, cdf_addr=0, in_ready=0 while reset is high.
- Accept at cycle 0 issues read k=0. icdf[k] is evaluated in cycle 1+k.
- Decoded symbol s sets out_valid in cycle 2+s, so latency is 2+s cycles (2 for illegal NSYMS).
- At most one read is outstanding; addresses strictly increment 0..s, with no reads beyond s.
- out_valid holds with constant outputs under backpressure. in_ready stays 0 until the cycle after the out handshake, giving a minimum of one IDLE cycle between requests.
- out_ready asserted while out_valid=0 is ignored. in_valid outside IDLE is ignored.

## Test plan
- Symbol 0: RNG=0x8000, DIF=0x6000, NSYMS=2, icdf={16384,0}.
  - Required: v0=16388, out_symbol=0, RNG_NEW=16380, DIF_NEW=8188.
  - out_valid at cycle 2; one memory read only (addr 0).
- Symbol 1: same request with DIF=0x2000.
  - Required: out_symbol=1, RNG_NEW=16388, DIF_NEW=8192.
  - out_valid at cycle 3; reads at addresses 0 and 1.
- Longest search: RNG=0xFFFF, DIF=0, NSYMS=16, icdf[14]=0x0400, icdf[15]=0, all other icdf>0.
  - Required: out_symbol=15, RNG_NEW=2044, DIF_NEW=0, out_valid at cycle 17.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - Required: outputs constant, in_ready=0 throughout.
  - After release: one IDLE cycle, then the next request is accepted.
- Illegal NSYMS (1, then 17): each must produce err_nsyms=1, out_symbol=0, RNG_NEW=RNG, DIF_NEW=DIF, out_valid at cycle 2, cdf_rd_en never asserted.
- Reset mid-SEARCH at k=3 of a 16-symbol request:
  - All outputs return to reset values next cycle and no out_valid follows.
  - A new request after reset decodes correctly.

Source files
------------

// File: rtl/dec_symbol_search.sv
// dec_symbol_search: multi-cycle AV1 inverse-CDF symbol search, one table entry per cycle
module dec_symbol_search #(
   parameter int RANGE_WIDTH  = 16,
   parameter int SYMBOL_WIDTH = 4
) (
   input  logic                    clk_dec_search,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [RANGE_WIDTH-1:0]  RNG,
   input  logic [RANGE_WIDTH-1:0]  DIF,
   input  logic [SYMBOL_WIDTH:0]   NSYMS,
   output logic                    cdf_rd_en,
   output logic [SYMBOL_WIDTH-1:0] cdf_addr,
   input  logic [RANGE_WIDTH-1:0]  cdf_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [SYMBOL_WIDTH-1:0] out_symbol,
   output logic [RANGE_WIDTH-1:0]  RNG_NEW,
   output logic [RANGE_WIDTH-1:0]  DIF_NEW,
   output logic                    err_nsyms
);
   localparam int RW = RANGE_WIDTH;
   localparam int SW = SYMBOL_WIDTH;
   typedef enum logic [1:0] {IDLE, SEARCH, ERR, DONE} state_t;
   state_t state;
   logic [SW-1:0] k, n;
   logic [RW-9:0] rng_hi;
   logic [RW-1:0] dif, u;
   logic [RW-7:0] icdf_hi;
   logic [2*RW-15:0] prod;
   logic [RW:0] v;
   logic legal, more;
   assign legal = NSYMS >= (SW+1)'(2) && NSYMS <= (SW+1)'(1 << SW);
   assign icdf_hi = (RW-6)'(cdf_data >> 6);
   assign prod = (2*RW-14)'(rng_hi) * (2*RW-14)'(icdf_hi);
   assign v = (RW+1)'(prod >> 1) + (RW+1)'({n - k, 2'b00});
   // keep walking while the window top is still below the scaled bound and symbols remain
   assign more = state == SEARCH && {1'b0, dif} < v && k != n;
   assign in_ready = !reset && state == IDLE;
   assign cdf_rd_en = !reset && ((state == IDLE && in_valid && legal) || more);
   assign cdf_addr = (!reset && more) ? k + SW'(1) : '0;
   always_ff @(posedge clk_dec_search) begin
      if (reset) begin
         state <= IDLE;
         k <= '0;
         n <= '0;
         rng_hi <= '0;
         dif <= '0;
         u <= '0;
         out_valid <= 1'b0;
         err_nsyms <= 1'b0;
         out_symbol <= '0;
         RNG_NEW <= '0;
         DIF_NEW <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               rng_hi <= (RW-8)'(RNG >> 8);
               dif <= DIF;
               u <= RNG;
               k <= '0;
               n <= NSYMS[SW-1:0] - SW'(1);
               state <= legal ? SEARCH : ERR;
            end
            SEARCH: if (more) begin
               u <= v[RW-1:0];
               k <= k + SW'(1);
            end else begin
               out_symbol <= k;
               RNG_NEW <= u - v[RW-1:0];
               DIF_NEW <= dif - v[RW-1:0];
               err_nsyms <= 1'b0;
               out_valid <= 1'b1;
               state <= DONE;
            end
            ERR: begin
               out_symbol <= '0;
               RNG_NEW <= u;
               DIF_NEW <= dif;
               err_nsyms <= 1'b1;
               out_valid <= 1'b1;
               state <= DONE;
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
